// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared state encoding and default sizing for the SAR ADC controller.
package sar_adc_pkg;
    localparam int N_BITS_DEF = 8;
    localparam int SAMPLE_CYCLES_DEF = 4;
    localparam int SETTLE_CYCLES_DEF = 1;
    typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, DECIDE, DONE} sar_state_t;
endpackage

// File: rtl/sar_cycle_timer.sv
// sar_cycle_timer: loadable down-counter with zero flag, shared by the sample and settle phases.
module sar_cycle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign zero = (cnt == '0);
endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation sequencer; samples, walks trial codes MSB first,
// and publishes the resolved code on a held result bus with a one-cycle done pulse.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic              cmp_in,
    output logic              sample_en,
    output logic [N_BITS-1:0] dac_code,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] result
);
    localparam int TMAX = SAMPLE_CYCLES > SETTLE_CYCLES ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam int KW = $clog2(N_BITS);
    localparam logic [TW-1:0] SAMPLE_LOAD = TW'(SAMPLE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
    localparam logic [KW-1:0] K_TOP = KW'(N_BITS - 1);
    localparam logic [N_BITS-1:0] MSB = {1'b1, {(N_BITS-1){1'b0}}};
    // with no settle time a new trial goes straight to the comparator decision
    localparam sar_state_t TRIAL_ST = SETTLE_CYCLES > 0 ? SETTLE : DECIDE;

    sar_state_t state, state_n;
    logic [KW-1:0] k, k_n;
    logic [N_BITS-1:0] dac_n, result_n, trial;
    logic sample_en_n, done_n, t_load, t_zero;
    logic [TW-1:0] t_val;

    sar_cycle_timer #(.W(TW)) u_timer (
        .clk(clk), .rst_n(rst_n), .load(t_load), .load_val(t_val), .zero(t_zero)
    );

    always_comb begin
        state_n = state;
        k_n = k;
        dac_n = dac_code;
        result_n = result;
        sample_en_n = 1'b0;
        done_n = 1'b0;
        t_load = 1'b0;
        t_val = SAMPLE_LOAD;
        trial = dac_code;
        trial[k] = cmp_in;
        if (abort && state inside {SAMPLE, SETTLE, DECIDE}) begin
            state_n = IDLE;
            dac_n = '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_n = SAMPLE;
                    sample_en_n = 1'b1;
                    t_load = 1'b1;
                end
                SAMPLE: if (t_zero) begin
                    state_n = TRIAL_ST;
                    k_n = K_TOP;
                    dac_n = MSB;
                    t_load = 1'b1;
                    t_val = SETTLE_LOAD;
                end else sample_en_n = 1'b1;
                SETTLE: if (t_zero) state_n = DECIDE;
                DECIDE: if (k == '0) begin
                    state_n = DONE;
                    done_n = 1'b1;
                    dac_n = trial;
                    result_n = trial;
                end else begin
                    state_n = TRIAL_ST;
                    dac_n = trial | (N_BITS'(1) << (k - 1'b1));
                    k_n = k - 1'b1;
                    t_load = 1'b1;
                    t_val = SETTLE_LOAD;
                end
                DONE: begin
                    dac_n = '0;
                    state_n = cont ? SAMPLE : IDLE;
                    sample_en_n = cont;
                    t_load = cont;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k <= '0;
            sample_en <= 1'b0;
            dac_code <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
        end else begin
            state <= state_n;
            k <= k_n;
            sample_en <= sample_en_n;
            dac_code <= dac_n;
            busy <= (state_n != IDLE);
            done <= done_n;
            result <= result_n;
        end
    end
endmodule
